// File: rtl/sa_tile_ws_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sa_tile_ws_pkg
// Purpose  : Shared types and helpers for the weight-stationary systolic tile:
//            control FSM state encoding, latency helper and word typedefs.
// Revision : 1.0 - initial release
// ============================================================================
package sa_tile_ws_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int WEIGHT_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF    = 32;

    typedef logic        [DATA_WIDTH_DEF-1:0]   act_word_t;
    typedef logic signed [WEIGHT_WIDTH_DEF-1:0] wt_word_t;
    typedef logic        [ACC_WIDTH_DEF-1:0]    acc_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } sa_state_e;

    // Input-accept to output-valid latency: skew/array traversal plus deskew.
    function automatic int sa_lat(input int rows, input int cols);
        return rows + cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_tile_ws_if.sv
`default_nettype none
// ============================================================================
// Module   : sa_tile_ws_if
// Purpose  : Bundle of the tile's activation handshake, weight-load and result
//            signals. master = activation/weight source, slave = tile.
// Ports    : act_signed, in_valid, in_ready, in_data, wt_valid, wt_row,
//            wt_data, wt_swap, swap_busy, out_valid, out_data
// Revision : 1.0 - initial release
// ============================================================================
interface sa_tile_ws_if #(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                                   act_signed;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [ROWS-1:0][DATA_WIDTH-1:0]        in_data;
    logic                                   wt_valid;
    logic [ROW_W-1:0]                       wt_row;
    logic [COLS-1:0][WEIGHT_WIDTH-1:0]      wt_data;
    logic                                   wt_swap;
    logic                                   swap_busy;
    logic                                   out_valid;
    logic [COLS-1:0][ACC_WIDTH-1:0]         out_data;

    modport master (
        output act_signed, in_valid, in_data, wt_valid, wt_row, wt_data, wt_swap,
        input  in_ready, swap_busy, out_valid, out_data
    );

    modport slave (
        input  act_signed, in_valid, in_data, wt_valid, wt_row, wt_data, wt_swap,
        output in_ready, swap_busy, out_valid, out_data
    );

endinterface
`default_nettype wire

// File: rtl/sa_tile_ws_pe.sv
`default_nettype none
// ============================================================================
// Module   : sa_pe_ws
// Purpose  : One weight-stationary processing element. Holds the active
//            weight, forwards the activation to the right one cycle later and
//            registers psum_out = psum_in + ext(a) * w downward.
// Ports    : clk, rst            clock, async active-high reset
//            i_act / o_act       {signed_flag, activation} in / registered out
//            i_psum / o_psum     partial sum in / registered out
//            i_shadow_wt         shadow weight for this PE
//            i_load              copy shadow weight into the active register
// Revision : 1.0 - initial release
// ============================================================================
module sa_pe_ws #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic [DATA_WIDTH:0]       i_act,
    input  wire logic [ACC_WIDTH-1:0]      i_psum,
    input  wire logic [WEIGHT_WIDTH-1:0]   i_shadow_wt,
    input  wire logic                      i_load,
    output logic      [DATA_WIDTH:0]       o_act,
    output logic      [ACC_WIDTH-1:0]      o_psum
);

    logic signed [WEIGHT_WIDTH-1:0] r_wt;
    logic signed [DATA_WIDTH:0]     w_act_ext;
    logic signed [ACC_WIDTH-1:0]    w_prod;

    // MSB of i_act is the signed-mode flag travelling with the activation:
    // one extra bit turns both modes into a plain signed operand.
    assign w_act_ext = {i_act[DATA_WIDTH] & i_act[DATA_WIDTH-1], i_act[DATA_WIDTH-1:0]};

    // Operands are sign-extended to ACC_WIDTH before multiplying, so the
    // low ACC_WIDTH bits are exact even when ACC_WIDTH is narrower than
    // the full product.
    assign w_prod = ACC_WIDTH'(w_act_ext) * ACC_WIDTH'(r_wt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wt   <= '0;
            o_act  <= '0;
            o_psum <= '0;
        end else begin
            if (i_load) begin
                r_wt <= i_shadow_wt;
            end
            o_act  <= i_act;
            o_psum <= i_psum + w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sa_tile_ws.sv
`default_nettype none
// ============================================================================
// Module   : sa_tile_ws
// Purpose  : Weight-stationary systolic tile. One ROWS-element activation
//            vector in per cycle, one aligned COLS-element result out per
//            cycle, LAT = ROWS+COLS cycles later. Input skew, output deskew,
//            shadow/active weights and a drain-then-swap control FSM.
// Ports    : clk, rst  clock, async active-high reset
//            bus       sa_tile_ws_if.slave (handshake, weight load, results)
// Revision : 1.0 - initial release
// ============================================================================
module sa_tile_ws
    import sa_tile_ws_pkg::*;
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sa_tile_ws_if.slave  bus
);

    localparam int LAT   = sa_lat(ROWS, COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    sa_state_e                               r_state;
    logic                                    r_ready;
    logic                                    r_swap_busy;
    logic [LAT-1:0]                          r_vsr;
    logic [ROWS-1:0][COLS-1:0][WEIGHT_WIDTH-1:0] r_shadow;
    logic [COLS-1:0][ACC_WIDTH-1:0]          r_out_data;

    logic                                    w_in_ready;
    logic                                    w_accept;
    logic                                    w_pipe_empty;
    logic                                    w_load;
    logic [ROWS-1:0][DATA_WIDTH:0]           w_row_act;
    logic [ROWS-1:0][COLS:0][DATA_WIDTH:0]   w_act_h;
    logic [ROWS:0][COLS-1:0][ACC_WIDTH-1:0]  w_psum;
    logic [COLS-1:0][ACC_WIDTH-1:0]          w_deskew;
    logic [ROWS-1:0][DATA_WIDTH:0]           w_unused_east;

    // A swap request blocks acceptance in the same cycle, before the FSM sees it.
    assign w_in_ready   = r_ready & ~rst & ~bus.wt_swap;
    assign w_accept     = bus.in_valid & w_in_ready;
    assign w_pipe_empty = (r_vsr == '0) & ~w_accept;
    assign w_load       = (r_state == ST_SWAP);

    assign bus.in_ready  = w_in_ready;
    assign bus.swap_busy = r_swap_busy;
    assign bus.out_valid = r_vsr[LAT-1];
    assign bus.out_data  = r_out_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_swap_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.wt_swap) begin
                        r_state     <= ST_DRAIN;
                        r_ready     <= 1'b0;
                        r_swap_busy <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.wt_swap) begin
                        r_state     <= ST_DRAIN;
                        r_ready     <= 1'b0;
                        r_swap_busy <= 1'b1;
                    end else if (w_pipe_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_swap_busy <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_swap_busy <= 1'b0;
                end
            endcase
        end
    end

    // Valid tracking: bit k set means an accepted vector is k+1 cycles old.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsr <= '0;
        end else begin
            r_vsr <= {r_vsr[LAT-2:0], w_accept};
        end
    end

    // Shadow weights: a write in the SWAP cycle lands after the copy because
    // the PEs sample the pre-edge shadow value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (bus.wt_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                if (bus.wt_row == ROW_W'(r)) begin
                    r_shadow[r] <= bus.wt_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row r delayed by r registers, signed flag alongside
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [DATA_WIDTH:0] w_tap_in;
        assign w_tap_in = {bus.act_signed, bus.in_data[r]};
        if (r == 0) begin : g_direct
            assign w_row_act[r] = w_tap_in;
        end else begin : g_delay
            logic [DATA_WIDTH:0] r_sk [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < r; i++) r_sk[i] <= '0;
                end else begin
                    r_sk[0] <= w_tap_in;
                    for (int i = 1; i < r; i++) r_sk[i] <= r_sk[i-1];
                end
            end
            assign w_row_act[r] = r_sk[r-1];
        end
    end

    // ------------------------------------------------------------------
    // PE array: activations flow right, partial sums flow down
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign w_act_h[r][0]    = w_row_act[r];
        assign w_unused_east[r] = w_act_h[r][COLS];
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (r == 0) begin : g_top
                assign w_psum[0][c] = '0;
            end
            sa_pe_ws #(
                .DATA_WIDTH   (DATA_WIDTH),
                .WEIGHT_WIDTH (WEIGHT_WIDTH),
                .ACC_WIDTH    (ACC_WIDTH)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .i_act       (w_act_h[r][c]),
                .i_psum      (w_psum[r][c]),
                .i_shadow_wt (r_shadow[r][c]),
                .i_load      (w_load),
                .o_act       (w_act_h[r][c+1]),
                .o_psum      (w_psum[r+1][c])
            );
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c delayed by COLS-1-c registers
    // ------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign w_deskew[c] = w_psum[ROWS][c];
        end else begin : g_delay
            logic [ACC_WIDTH-1:0] r_dk [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) r_dk[i] <= '0;
                end else begin
                    r_dk[0] <= w_psum[ROWS][c];
                    for (int i = 1; i < D; i++) r_dk[i] <= r_dk[i-1];
                end
            end
            assign w_deskew[c] = r_dk[D-1];
        end
    end

    // Output register only loads for a valid vector, so out_data holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (r_vsr[LAT-2]) begin
            r_out_data <= w_deskew;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_tile_ws
// Purpose  : Self-checking bench for sa_tile_ws (ROWS=COLS=4, LAT=8) with a
//            cycle-level behavioural reference model, plus a 16-bit
//            accumulator instance for the wrap case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_tile_ws;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int AW   = 32;
    localparam int LAT  = ROWS + COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_tile_ws_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();
    sa_tile_ws_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(16)) bus16 ();

    sa_tile_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    sa_tile_ws #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(16)) dut16 (
        .clk (clk), .rst (rst), .bus (bus16.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: results scheduled LAT cycles after acceptance,
    // weight swap modelled from the drain rule (pipe empty LAT+1 cycles
    // after the last acceptance), shadow/active as plain arrays.
    // ------------------------------------------------------------------
    int           cyc = 0;
    logic [WW-1:0] m_shadow [ROWS][COLS];
    logic [WW-1:0] m_active [ROWS][COLS];
    bit           m_busy = 0;
    int           m_swap_at = 0;
    int           m_last_acc = -1000;
    bit           exp_v [64];
    logic [AW-1:0] exp_d [64][COLS];
    logic [AW-1:0] m_last [COLS];

    always @(negedge clk) begin
        int     slot;
        int     nslot;
        bit     exp_ready;
        longint s;
        longint av;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_swap_busy", bus.swap_busy, 0);
            for (int c = 0; c < COLS; c++) chk("rst_out_data", bus.out_data[c], 0);
            for (int i = 0; i < 64; i++) exp_v[i] = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    m_shadow[r][c] = '0;
                    m_active[r][c] = '0;
                end
            for (int c = 0; c < COLS; c++) m_last[c] = '0;
            m_busy     = 0;
            m_last_acc = -1000;
        end else begin
            slot = cyc % 64;
            chk("out_valid", bus.out_valid, exp_v[slot]);
            if (exp_v[slot]) for (int c = 0; c < COLS; c++) m_last[c] = exp_d[slot][c];
            for (int c = 0; c < COLS; c++) chk("out_data", bus.out_data[c], m_last[c]);
            exp_v[slot] = 0;
            exp_ready = !m_busy && !bus.wt_swap;
            chk("in_ready", bus.in_ready, exp_ready);
            chk("swap_busy", bus.swap_busy, m_busy);
            if (bus.in_valid && exp_ready) begin
                nslot = (cyc + LAT) % 64;
                for (int c = 0; c < COLS; c++) begin
                    s = 0;
                    for (int r = 0; r < ROWS; r++) begin
                        av = bus.act_signed ? longint'($signed(bus.in_data[r])) : longint'(bus.in_data[r]);
                        s += av * longint'($signed(m_active[r][c]));
                    end
                    exp_d[nslot][c] = s[AW-1:0];
                end
                exp_v[nslot] = 1;
                m_last_acc = cyc;
            end
            if (bus.wt_swap && !m_busy) begin
                m_busy    = 1;
                m_swap_at = ((cyc + 1 > m_last_acc + LAT + 1) ? cyc + 1 : m_last_acc + LAT + 1) + 1;
            end else if (m_busy && cyc == m_swap_at) begin
                m_active = m_shadow;
                m_busy   = 0;
            end
            if (bus.wt_valid)
                for (int c = 0; c < COLS; c++) m_shadow[bus.wt_row][c] = bus.wt_data[c];
        end
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [WW-1:0] w_buf [ROWS][COLS];
    logic [DW-1:0] a_buf [ROWS];
    logic [AW-1:0] e_buf [COLS];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w();
        for (int r = 0; r < ROWS; r++) begin
            bus.wt_valid = 1'b1;
            bus.wt_row   = 2'(r);
            for (int c = 0; c < COLS; c++) bus.wt_data[c] = w_buf[r][c];
            step();
        end
        bus.wt_valid = 1'b0;
    endtask

    task automatic do_swap();
        int n = 0;
        bus.wt_swap = 1'b1;
        step();
        bus.wt_swap = 1'b0;
        while (bus.swap_busy && n < 40) begin
            step();
            n++;
        end
        chk("swap_done", bus.swap_busy, 0);
    endtask

    task automatic drive_vec(input bit sgn);
        bus.in_valid   = 1'b1;
        bus.act_signed = sgn;
        for (int r = 0; r < ROWS; r++) bus.in_data[r] = a_buf[r];
    endtask

    task automatic rand_a();
        for (int r = 0; r < ROWS; r++) a_buf[r] = DW'($urandom);
    endtask

    // Accept one vector at T; expect nothing at T+7, e_buf at T+8, nothing at T+9.
    task automatic send_check(input bit sgn, input string tag);
        drive_vec(sgn);
        @(negedge clk);
        chk({tag, "_accept_ready"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        repeat (LAT - 2) step();
        @(negedge clk);
        chk({tag, "_early"}, bus.out_valid, 0);
        step();
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        for (int c = 0; c < COLS; c++) chk({tag, "_data"}, bus.out_data[c], e_buf[c]);
        step();
        @(negedge clk);
        chk({tag, "_late"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int cnt;
        int run;
        int best;
        int lat16;
        bus.in_valid = 0; bus.act_signed = 0; bus.in_data = '0;
        bus.wt_valid = 0; bus.wt_row = '0; bus.wt_data = '0; bus.wt_swap = 0;
        bus16.in_valid = 0; bus16.act_signed = 0; bus16.in_data = '0;
        bus16.wt_valid = 0; bus16.wt_row = '0; bus16.wt_data = '0; bus16.wt_swap = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.in_ready, 1);
        chk("out_data0_after_reset", bus.out_data[0], 0);

        // Identity weights
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_buf[r][c] = (r == c) ? 8'd1 : 8'd0;
        step();
        load_w();
        do_swap();
        for (int r = 0; r < ROWS; r++) a_buf[r] = 8'(r + 1);
        e_buf[0] = 1; e_buf[1] = 2; e_buf[2] = 3; e_buf[3] = 4;
        send_check(1'b0, "ident");

        // Signed extreme: -128 * -128 * 4
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_buf[r][c] = 8'h80;
        load_w();
        do_swap();
        for (int r = 0; r < ROWS; r++) a_buf[r] = 8'h80;
        for (int c = 0; c < COLS; c++) e_buf[c] = 32'd65536;
        send_check(1'b1, "neg128");

        // Unsigned 0xFF with W=1
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_buf[r][c] = 8'd1;
        load_w();
        do_swap();
        for (int r = 0; r < ROWS; r++) a_buf[r] = 8'hFF;
        for (int c = 0; c < COLS; c++) e_buf[c] = 32'd1020;
        send_check(1'b0, "uns255");

        // 20 back-to-back random vectors
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_buf[r][c] = WW'($urandom);
        load_w();
        do_swap();
        cnt = 0; run = 0; best = 0;
        for (int i = 0; i < 20; i++) begin
            rand_a();
            drive_vec(1'($urandom));
            @(negedge clk);
            chk("b2b_ready", bus.in_ready, 1);
            if (bus.out_valid) begin cnt++; run++; if (run > best) best = run; end else run = 0;
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin cnt++; run++; if (run > best) best = run; end else run = 0;
            step();
        end
        chk("b2b_count", cnt, 20);
        chk("b2b_consecutive", best, 20);

        // Swap requested mid-stream with new shadow already loaded
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) w_buf[r][c] = WW'($urandom);
        load_w();
        for (int i = 0; i < 5; i++) begin
            rand_a();
            drive_vec(1'($urandom));
            @(negedge clk);
            chk("ms_ready", bus.in_ready, 1);
            step();
        end
        rand_a();
        drive_vec(1'b1);
        bus.wt_swap = 1'b1;
        @(negedge clk);
        chk("swap_blocks_ready", bus.in_ready, 0);
        step();
        bus.wt_swap = 1'b0;
        repeat (8) step();
        bus.wt_valid = 1'b1;
        bus.wt_row   = 2'd0;
        for (int c = 0; c < COLS; c++) bus.wt_data[c] = WW'($urandom);
        @(negedge clk);
        chk("swap_cycle_busy", bus.swap_busy, 1);
        chk("swap_cycle_ready", bus.in_ready, 0);
        step();
        bus.wt_valid = 1'b0;
        @(negedge clk);
        chk("post_swap_ready", bus.in_ready, 1);
        chk("post_swap_busy", bus.swap_busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            rand_a();
            drive_vec(1'($urandom));
        end
        step();
        bus.in_valid = 1'b0;
        repeat (LAT + 2) step();
        do_swap();
        rand_a();
        drive_vec(1'b0);
        step();
        bus.in_valid = 1'b0;
        repeat (LAT + 2) step();

        // Reset with three vectors in flight
        for (int i = 0; i < 3; i++) begin
            rand_a();
            drive_vec(1'($urandom));
            step();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", bus.in_ready, 1);
        for (int c = 0; c < COLS; c++) chk("data_after_midrst", bus.out_data[c], 0);
        cnt = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
            step();
        end
        chk("no_valid_after_midrst", cnt, 0);
        rand_a();
        a_buf[0] = 8'd77;
        for (int c = 0; c < COLS; c++) e_buf[c] = '0;
        send_check(1'b1, "zero_w");

        // 16-bit accumulator wrap
        for (int r = 0; r < ROWS; r++) begin
            bus16.wt_valid = 1'b1;
            bus16.wt_row   = 2'(r);
            for (int c = 0; c < COLS; c++) bus16.wt_data[c] = 8'd127;
            step();
        end
        bus16.wt_valid = 1'b0;
        bus16.wt_swap  = 1'b1;
        step();
        bus16.wt_swap  = 1'b0;
        repeat (4) step();
        bus16.in_valid   = 1'b1;
        bus16.act_signed = 1'b1;
        for (int r = 0; r < ROWS; r++) bus16.in_data[r] = 8'd127;
        lat16 = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            bus16.in_valid = 1'b0;
            @(negedge clk);
            if (bus16.out_valid) begin lat16 = k; break; end
        end
        chk("acc16_latency", lat16, LAT);
        for (int c = 0; c < COLS; c++) begin
            chk("acc16_data", bus16.out_data[c], 16'd64516);
            chk("acc16_signed", int'($signed(bus16.out_data[c])), -1020);
        end

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
